// File: rtl/demux_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// demux_ctrl_pkg
// Shared definitions for the burst-steering demultiplexer:
//   - state_e   : controller states (IDLE / RUN / DRAIN)
//   - CH_B/CH_C : channel encodings used by the hold register and sel_cur
//   - ch_select : channel chosen at a burst boundary
//   - ch_other  : round-robin successor of a channel
// -----------------------------------------------------------------------------
package demux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic CH_B = 1'b0;
    localparam logic CH_C = 1'b1;

    // Forced mode takes sel_force, otherwise the round-robin pointer decides.
    function automatic logic ch_select(input logic mode_i,
                                       input logic sel_force_i,
                                       input logic rr_next_i);
        logic ch;
        if (mode_i) begin
            ch = sel_force_i;
        end else begin
            ch = rr_next_i;
        end
        return ch;
    endfunction

    // With two channels the round-robin successor is simply the other one.
    function automatic logic ch_other(input logic ch_i);
        return ~ch_i;
    endfunction

endpackage

// File: rtl/demux_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// demux_burst_ctrl_if
// Streaming bus of the burst demultiplexer: one valid/ready input stream and
// two valid/ready output streams (channels B and C).
//   slave  : the demultiplexer side (consumes in_*, produces outB_*/outC_*)
//   master : the environment side (producer + both consumers)
// -----------------------------------------------------------------------------
interface demux_burst_ctrl_if #(
    parameter int DATA_W = 2
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] outB_data;
    logic              outB_valid;
    logic              outB_ready;
    logic [DATA_W-1:0] outC_data;
    logic              outC_valid;
    logic              outC_ready;

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output outB_data, outB_valid,
        input  outB_ready,
        output outC_data, outC_valid,
        input  outC_ready
    );

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  outB_data, outB_valid,
        output outB_ready,
        input  outC_data, outC_valid,
        output outC_ready
    );
endinterface

// File: rtl/demux_hold_reg.sv
// -----------------------------------------------------------------------------
// demux_hold_reg
// Single-entry output register shared by both channels. The entry carries the
// data word, its channel and a last-of-burst flag. Per-channel valid and data
// are kept in their own flops so every output port is driven straight from a
// register; the idle channel's data flop holds zero.
// Ports:
//   clk, rst           clock, async active-high reset
//   load               write a new entry (takes priority over consume)
//   ld_data/ld_ch/ld_last  entry contents on load
//   b_ready, c_ready   consumer ready per channel
//   valid, last        entry occupied / entry is last word of a burst
//   consume            entry is taken by its channel this cycle
//   b_data/b_valid, c_data/c_valid  channel outputs
// -----------------------------------------------------------------------------
module demux_hold_reg
    import demux_ctrl_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_ch,
    input  logic              ld_last,
    input  logic              b_ready,
    input  logic              c_ready,
    output logic              valid,
    output logic              last,
    output logic              consume,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic [DATA_W-1:0] c_data,
    output logic              c_valid
);

    logic [DATA_W-1:0] b_data_r;
    logic [DATA_W-1:0] c_data_r;
    logic              b_valid_r;
    logic              c_valid_r;
    logic              last_r;

    // Only the channel owning the entry looks at its consumer's ready.
    assign consume = (b_valid_r & b_ready) | (c_valid_r & c_ready);
    assign valid   = b_valid_r | c_valid_r;
    assign last    = last_r;
    assign b_data  = b_data_r;
    assign b_valid = b_valid_r;
    assign c_data  = c_data_r;
    assign c_valid = c_valid_r;

    // Entry storage: load overwrites (also when the old word leaves this cycle),
    // consume alone empties; data stays put after consume so outputs are stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data_r  <= '0;
            c_data_r  <= '0;
            b_valid_r <= 1'b0;
            c_valid_r <= 1'b0;
            last_r    <= 1'b0;
        end else if (load) begin
            b_valid_r <= (ld_ch == CH_B);
            c_valid_r <= (ld_ch == CH_C);
            b_data_r  <= (ld_ch == CH_B) ? ld_data : '0;
            c_data_r  <= (ld_ch == CH_C) ? ld_data : '0;
            last_r    <= ld_last;
        end else if (consume) begin
            b_valid_r <= 1'b0;
            c_valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_burst_ctrl.sv
// -----------------------------------------------------------------------------
// demux_burst_ctrl
// Streaming 1-to-2 demultiplexer. Input words are steered in atomic bursts of
// BURST_LEN words to channel B or C; the channel is picked (round-robin or
// forced) only when a burst starts. Every burst is followed by a DRAIN cycle in
// which input is blocked until the last word has left the hold register.
// Ports:
//   clk, rst    clock, async active-high reset
//   bus         slave side of demux_burst_ctrl_if (in_*, outB_*, outC_*)
//   mode        0 = round-robin, 1 = forced channel
//   sel_force   forced channel when mode=1 (0 = B, 1 = C)
//   sel_cur     channel of the current / most recent burst
//   burst_done  one-cycle pulse after the last word of a burst is consumed
// -----------------------------------------------------------------------------
module demux_burst_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int DATA_W    = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    demux_burst_ctrl_if.slave   bus,
    input  logic                mode,
    input  logic                sel_force,
    output logic                sel_cur,
    output logic                burst_done
);

    localparam int               CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(BURST_LEN);

    state_e            state_r;
    logic [CNT_W-1:0]  count_r;
    logic              rr_next_r;
    logic              sel_cur_r;
    logic              burst_done_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              ld_ch_s;
    logic              ld_last_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              hold_valid_s;
    logic              hold_last_s;
    logic              consume_s;
    logic [DATA_W-1:0] b_data_s;
    logic              b_valid_s;
    logic [DATA_W-1:0] c_data_s;
    logic              c_valid_s;

    // Input readiness and the channel / last flag of a word accepted this cycle.
    always_comb begin
        in_ready_s  = 1'b0;
        ld_ch_s     = sel_cur_r;
        ld_last_s   = 1'b0;
        count_inc_s = count_r + CNT_W'(1);
        // rst gates ready combinationally so nothing is offered as accepted
        // while reset is held, independent of register state.
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_DRAIN) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !hold_valid_s || consume_s;
        end
        case (state_r)
            ST_IDLE: begin
                ld_ch_s   = ch_select(mode, sel_force, rr_next_r);
                ld_last_s = (LEN_C == CNT_W'(1));
            end
            ST_RUN: begin
                ld_ch_s   = sel_cur_r;
                ld_last_s = (count_inc_s == LEN_C);
            end
            default: begin
                ld_ch_s   = sel_cur_r;
                ld_last_s = 1'b0;
            end
        endcase
    end

    assign accept_s      = bus.in_valid & in_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.outB_data = b_data_s;
    assign bus.outB_valid = b_valid_s;
    assign bus.outC_data = c_data_s;
    assign bus.outC_valid = c_valid_s;
    assign sel_cur       = sel_cur_r;
    assign burst_done    = burst_done_r;

    demux_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .ld_data (bus.in_data),
        .ld_ch   (ld_ch_s),
        .ld_last (ld_last_s),
        .b_ready (bus.outB_ready),
        .c_ready (bus.outC_ready),
        .valid   (hold_valid_s),
        .last    (hold_last_s),
        .consume (consume_s),
        .b_data  (b_data_s),
        .b_valid (b_valid_s),
        .c_data  (c_data_s),
        .c_valid (c_valid_s)
    );

    // Burst sequencer: channel latch, word counter, round-robin pointer, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            rr_next_r    <= CH_B;
            sel_cur_r    <= CH_B;
            burst_done_r <= 1'b0;
        end else begin
            burst_done_r <= consume_s & hold_last_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sel_cur_r <= ld_ch_s;
                        count_r   <= CNT_W'(1);
                        state_r   <= ld_last_s ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        count_r <= count_inc_s;
                        if (ld_last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the last word is gone or leaves on this edge.
                    if (!hold_valid_s || consume_s) begin
                        count_r   <= '0;
                        rr_next_r <= ch_other(sel_cur_r);
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    count_r <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_burst_ctrl
// Directed bench for demux_burst_ctrl. Two instances share the stimulus: one
// with BURST_LEN=4 and one with BURST_LEN=1; use1 selects which instance the
// driver handshakes with and the monitor observes.
// -----------------------------------------------------------------------------
module tb_demux_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic       in_valid;
    logic       b_ready;
    logic       c_ready;
    logic       mode;
    logic       sel_force;
    logic       use1;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         cyc     = 0;
    int         done_cnt = 0;
    logic       both_hi = 1'b0;
    logic [1:0] q_b[$];
    logic [1:0] q_c[$];
    int         q_t[$];

    always #5 clk = ~clk;

    demux_burst_ctrl_if #(.DATA_W(2)) bus4 ();
    demux_burst_ctrl_if #(.DATA_W(2)) bus1 ();

    assign bus4.in_data    = in_data;
    assign bus4.in_valid   = in_valid;
    assign bus4.outB_ready = b_ready;
    assign bus4.outC_ready = c_ready;
    assign bus1.in_data    = in_data;
    assign bus1.in_valid   = in_valid;
    assign bus1.outB_ready = b_ready;
    assign bus1.outC_ready = c_ready;

    logic sel_cur4, done4, sel_cur1, done1;

    demux_burst_ctrl #(.DATA_W(2), .BURST_LEN(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus4),
        .mode       (mode),
        .sel_force  (sel_force),
        .sel_cur    (sel_cur4),
        .burst_done (done4)
    );

    demux_burst_ctrl #(.DATA_W(2), .BURST_LEN(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1),
        .mode       (mode),
        .sel_force  (sel_force),
        .sel_cur    (sel_cur1),
        .burst_done (done1)
    );

    logic       in_ready_m, b_valid_m, c_valid_m, sel_cur_m, done_m;
    logic [1:0] b_data_m, c_data_m;
    assign in_ready_m = use1 ? bus1.in_ready   : bus4.in_ready;
    assign b_valid_m  = use1 ? bus1.outB_valid : bus4.outB_valid;
    assign c_valid_m  = use1 ? bus1.outC_valid : bus4.outC_valid;
    assign b_data_m   = use1 ? bus1.outB_data  : bus4.outB_data;
    assign c_data_m   = use1 ? bus1.outC_data  : bus4.outC_data;
    assign sel_cur_m  = use1 ? sel_cur1        : sel_cur4;
    assign done_m     = use1 ? done1           : done4;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only move #1 after posedge, so a handshake seen at negedge
    // completes on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (b_valid_m && b_ready) begin
                q_b.push_back(b_data_m);
                q_t.push_back(cyc);
            end
            if (c_valid_m && c_ready) begin
                q_c.push_back(c_data_m);
                q_t.push_back(cyc);
            end
            if (done_m) done_cnt++;
            if (b_valid_m && c_valid_m) both_hi = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] q[$]);
        logic [31:0] acc = 32'd0;
        foreach (q[i]) acc = (acc << 2) | 32'(q[i]);
        return acc;
    endfunction

    task automatic clear_log();
        q_b.delete();
        q_c.delete();
        q_t.delete();
        done_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_m) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = 2'd0; in_valid = 1'b0; b_ready = 1'b1; c_ready = 1'b1;
        mode = 1'b0; sel_force = 1'b0; use1 = 1'b0;

        // 1. reset state
        step(2);
        check("rst_in_ready", 32'(in_ready_m), 32'd0);
        check("rst_b_valid",  32'(b_valid_m),  32'd0);
        check("rst_c_valid",  32'(c_valid_m),  32'd0);
        check("rst_sel_cur",  32'(sel_cur_m),  32'd0);
        check("rst_done",     32'(done_m),     32'd0);
        rst = 1'b0;
        step(1);
        check("rel_in_ready", 32'(in_ready_m), 32'd1);

        // 2. round-robin, back-to-back, both consumers ready
        clear_log();
        send(2'd0);
        check("rr_sel_cur_b", 32'(sel_cur_m), 32'd0);
        send(2'd1); send(2'd2); send(2'd3);
        send(2'd0); send(2'd1); send(2'd2); send(2'd3);
        step(4);
        check("rr_b_n",    32'(q_b.size()), 32'd4);
        check("rr_b_data", pack(q_b),       32'h1B);
        check("rr_c_n",    32'(q_c.size()), 32'd4);
        check("rr_c_data", pack(q_c),       32'h1B);
        check("rr_done",   32'(done_cnt),   32'd2);
        check("rr_sel_cur_c", 32'(sel_cur_m), 32'd1);
        check("rr_b2b",    32'(q_t[3] - q_t[0]), 32'd3);
        check("rr_gap",    32'(q_t[4] - q_t[3]), 32'd2);

        // 3. backpressure on B after the second word
        clear_log();
        send(2'd0); send(2'd1);
        b_ready = 1'b0; in_valid = 1'b1; in_data = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready_m), 32'd0);
            check("bp_b_data",   32'(b_data_m),   32'd1);
        end
        @(posedge clk); #1;
        b_ready = 1'b1;
        send(2'd2); send(2'd3);
        step(4);
        check("bp_b_n",    32'(q_b.size()), 32'd4);
        check("bp_b_data_seq", pack(q_b),   32'h1B);
        check("bp_c_n",    32'(q_c.size()), 32'd0);
        check("bp_done",   32'(done_cnt),   32'd1);

        // 4. forced mode, sel_force flips mid-burst
        clear_log();
        mode = 1'b1; sel_force = 1'b1;
        send(2'd3); send(2'd2);
        sel_force = 1'b0;
        send(2'd1); send(2'd0);
        send(2'd2); send(2'd2); send(2'd1); send(2'd1);
        step(4);
        check("frc_c_n",    32'(q_c.size()), 32'd4);
        check("frc_c_data", pack(q_c),       32'hE4);
        check("frc_b_n",    32'(q_b.size()), 32'd4);
        check("frc_b_data", pack(q_b),       32'hA5);
        check("frc_done",   32'(done_cnt),   32'd2);

        // 5. reset in the middle of a C burst
        sel_force = 1'b1;
        send(2'd1); send(2'd2);
        check("mid_c_valid_pre", 32'(c_valid_m), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_c_valid", 32'(c_valid_m),  32'd0);
        check("mid_c_data",  32'(c_data_m),   32'd0);
        check("mid_in_ready", 32'(in_ready_m), 32'd0);
        step(2);
        rst = 1'b0;
        clear_log();
        mode = 1'b0;
        send(2'd0); send(2'd3); send(2'd0); send(2'd3);
        step(4);
        check("mid_b_n",    32'(q_b.size()), 32'd4);
        check("mid_b_data", pack(q_b),       32'h33);
        check("mid_c_n",    32'(q_c.size()), 32'd0);
        check("mid_done",   32'(done_cnt),   32'd1);

        // 6. BURST_LEN=1 instance, round-robin single-word bursts
        rst = 1'b1;
        use1 = 1'b1;
        step(2);
        rst = 1'b0;
        clear_log();
        send(2'd1); send(2'd2); send(2'd3); send(2'd0); send(2'd1);
        step(4);
        check("l1_b_n",    32'(q_b.size()), 32'd3);
        check("l1_b_data", pack(q_b),       32'h1D);
        check("l1_c_n",    32'(q_c.size()), 32'd2);
        check("l1_c_data", pack(q_c),       32'h08);
        check("l1_done",   32'(done_cnt),   32'd5);
        check("l1_spacing", 32'(q_t[4] - q_t[0]), 32'd8);

        check("never_both_valid", 32'(both_hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
